keccak_sponge_ctrl: RTL and testbench

//  Parametrised sponge controller for the SHAKE/SHA3 core; drives the Keccak datapath.

---
 rtl/keccak_pkg.sv | 41 ++++
 rtl/keccak_round_counter.sv | 33 +++
 rtl/keccak_sponge_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_keccak_sponge_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared types and helpers for the Keccak sponge controller.
package keccak_pkg;

  localparam int unsigned KECCAK_ROUNDS = 24;
  localparam int unsigned ROUND_IDX_W   = 5;
  localparam int unsigned LANE_CNT_W    = 5;

  typedef enum logic [1:0] {
    MODE_SHAKE128 = 2'd0,
    MODE_SHAKE256 = 2'd1,
    MODE_SHA3_256 = 2'd2,
    MODE_SHA3_512 = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_WAIT_ABSORB = 3'd1,
    ST_XOR         = 3'd2,
    ST_PERMUTE     = 3'd3,
    ST_DUMP        = 3'd4,
    ST_SQUEEZE     = 3'd5
  } ctrl_state_t;

  // Rate of each mode in 64-bit lanes.
  function automatic logic [LANE_CNT_W-1:0] rate_lanes_f(input mode_t mode);
    logic [LANE_CNT_W-1:0] lanes;
    case (mode)
      MODE_SHAKE128: lanes = LANE_CNT_W'(21);
      MODE_SHAKE256: lanes = LANE_CNT_W'(17);
      MODE_SHA3_256: lanes = LANE_CNT_W'(17);
      MODE_SHA3_512: lanes = LANE_CNT_W'(9);
      default:       lanes = LANE_CNT_W'(21);
    endcase
    return lanes;
  endfunction

  function automatic logic is_sha3_f(input mode_t mode);
    return (mode == MODE_SHA3_256) || (mode == MODE_SHA3_512);
  endfunction

endpackage

// File: rtl/keccak_round_counter.sv
// Round index generator: steps by ROUNDS_PER_CYCLE while enabled, wraps to 0 after the last step.
module keccak_round_counter
  import keccak_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  output logic [ROUND_IDX_W-1:0] round_idx_o,
  output logic                   round_done_o
);

  localparam int unsigned LAST_IDX = KECCAK_ROUNDS - ROUNDS_PER_CYCLE;

  logic [ROUND_IDX_W-1:0] idx_q, idx_d;

  assign round_done_o = (idx_q == ROUND_IDX_W'(LAST_IDX));
  assign round_idx_o  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (en_i) begin
      idx_d = round_done_o ? '0 : idx_q + ROUND_IDX_W'(ROUNDS_PER_CYCLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// Sponge controller sequencing absorb, permute and squeeze for the Keccak datapath.
// Optional KECCAK_CTRL_PERF_EN adds permutation and stall counters.
module keccak_sponge_ctrl
  import keccak_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned OUT_CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  mode_t                  cfg_mode,
  input  logic [OUT_CNT_W-1:0]   cfg_out_blocks,
  input  logic                   input_buffer_ready,
  input  logic                   last_block_in_input_buffer,
  output logic                   input_buffer_ready_clr,
  output logic                   last_block_in_buffer_clr,
  input  logic                   output_buffer_available,
  output logic                   output_buffer_available_clr,
  output logic                   output_buffer_we,
  output logic                   last_output_block_wr,
  output logic                   state_reset,
  output logic                   absorb_enable,
  output logic                   round_en,
  output logic [ROUND_IDX_W-1:0] round_idx,
  output logic                   copy_control_data,
  output logic [LANE_CNT_W-1:0]  rate_lanes,
  output logic                   busy
`ifdef KECCAK_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_perm_cnt,
  output logic [31:0]            perf_stall_cnt
`endif
);

  ctrl_state_t            state_q, state_d;
  logic                   last_q, last_d;
  logic                   fresh_q, fresh_d;
  logic                   open_q, open_d;
  logic [OUT_CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [OUT_CNT_W-1:0]   out_blocks_q;
  mode_t                  mode_q;
  logic                   round_done;
  logic                   final_blk;

  keccak_round_counter #(
    .ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)
  ) u_round_counter (
    .clk         (clk),
    .rst         (rst),
    .en_i        (round_en),
    .round_idx_o (round_idx),
    .round_done_o(round_done)
  );

  assign final_blk                   = (blk_cnt_q == out_blocks_q);
  assign rate_lanes                  = rate_lanes_f(mode_q);
  assign output_buffer_available_clr = output_buffer_we;

  // Next state and datapath strobes; fresh_q marks an XOR that starts a chained message.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    fresh_d   = fresh_q;
    open_d    = open_q;
    blk_cnt_d = blk_cnt_q;

    state_reset              = 1'b0;
    absorb_enable            = 1'b0;
    round_en                 = 1'b0;
    input_buffer_ready_clr   = 1'b0;
    last_block_in_buffer_clr = 1'b0;
    output_buffer_we         = 1'b0;
    last_output_block_wr     = 1'b0;
    copy_control_data        = 1'b0;
    busy                     = 1'b1;

    case (state_q)
      ST_RESET: begin
        state_reset              = 1'b1;
        input_buffer_ready_clr   = 1'b1;
        last_block_in_buffer_clr = 1'b1;
        state_d                  = ST_WAIT_ABSORB;
      end
      ST_WAIT_ABSORB: begin
        busy = 1'b0;
        if (input_buffer_ready) begin
          copy_control_data = !open_q;
          open_d            = 1'b1;
          state_d           = ST_XOR;
        end
      end
      ST_XOR: begin
        absorb_enable            = 1'b1;
        input_buffer_ready_clr   = 1'b1;
        last_block_in_buffer_clr = last_block_in_input_buffer;
        last_d                   = last_block_in_input_buffer;
        state_reset              = fresh_q;
        copy_control_data        = fresh_q;
        fresh_d                  = 1'b0;
        open_d                   = 1'b1;
        state_d                  = ST_PERMUTE;
      end
      ST_PERMUTE: begin
        round_en = 1'b1;
        if (round_done) begin
          if (last_q)                  state_d = ST_DUMP;
          else if (input_buffer_ready) state_d = ST_XOR;
          else                         state_d = ST_WAIT_ABSORB;
        end
      end
      ST_DUMP: begin
        output_buffer_we     = output_buffer_available;
        last_output_block_wr = output_buffer_available && final_blk;
        if (output_buffer_available) begin
          if (final_blk) begin
            state_reset = 1'b1;
            blk_cnt_d   = '0;
            last_d      = 1'b0;
            open_d      = 1'b0;
            if (input_buffer_ready) begin
              fresh_d = 1'b1;
              state_d = ST_XOR;
            end else begin
              state_d = ST_WAIT_ABSORB;
            end
          end else begin
            blk_cnt_d = blk_cnt_q + OUT_CNT_W'(1);
            state_d   = ST_SQUEEZE;
          end
        end
      end
      ST_SQUEEZE: begin
        round_en = 1'b1;
        if (round_done) state_d = ST_DUMP;
      end
      default: state_d = ST_RESET;
    endcase

    // Reset silences every strobe immediately, before the clock sees it.
    if (rst) begin
      state_reset              = 1'b0;
      absorb_enable            = 1'b0;
      round_en                 = 1'b0;
      input_buffer_ready_clr   = 1'b0;
      last_block_in_buffer_clr = 1'b0;
      output_buffer_we         = 1'b0;
      last_output_block_wr     = 1'b0;
      copy_control_data        = 1'b0;
      busy                     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET;
      last_q    <= 1'b0;
      fresh_q   <= 1'b0;
      open_q    <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      fresh_q   <= fresh_d;
      open_q    <= open_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  // Message configuration; SHA3 digests are always a single block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_SHAKE128;
      out_blocks_q <= '0;
    end else if (copy_control_data) begin
      mode_q       <= cfg_mode;
      out_blocks_q <= is_sha3_f(cfg_mode) ? '0 : cfg_out_blocks;
    end
  end

`ifdef KECCAK_CTRL_PERF_EN
  logic perm_evt;
  logic stall_evt;

  assign perm_evt  = round_en && round_done;
  assign stall_evt = ((state_q == ST_DUMP) && !output_buffer_available) ||
                     ((state_q == ST_WAIT_ABSORB) && open_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_perm_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (perm_evt && (perf_perm_cnt != '1))   perf_perm_cnt  <= perf_perm_cnt + 32'd1;
      if (stall_evt && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Directed bench for keccak_sponge_ctrl; instances 0/1/2 use ROUNDS_PER_CYCLE 1/4/24.
module tb_keccak_sponge_ctrl;
  import keccak_pkg::*;

  localparam int unsigned OUT_CNT_W = 16;
  localparam int unsigned N_DUT     = 3;

  logic clk = 1'b0;
  logic rst;
  mode_t cfg_mode;
  logic [OUT_CNT_W-1:0] cfg_out_blocks;
  logic ibr, lbi, avail;

  logic ibr_clr [N_DUT];
  logic lb_clr [N_DUT];
  logic avail_clr [N_DUT];
  logic we [N_DUT];
  logic last_wr [N_DUT];
  logic st_rst [N_DUT];
  logic absorb [N_DUT];
  logic ren [N_DUT];
  logic copy [N_DUT];
  logic busy [N_DUT];
  logic [4:0] ridx [N_DUT];
  logic [4:0] rate [N_DUT];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int unsigned RPC = (g == 0) ? 1 : ((g == 1) ? 4 : 24);
    keccak_sponge_ctrl #(.ROUNDS_PER_CYCLE(RPC), .OUT_CNT_W(OUT_CNT_W)) u_dut (
      .clk                        (clk),
      .rst                        (rst),
      .cfg_mode                   (cfg_mode),
      .cfg_out_blocks             (cfg_out_blocks),
      .input_buffer_ready         (ibr),
      .last_block_in_input_buffer (lbi),
      .input_buffer_ready_clr     (ibr_clr[g]),
      .last_block_in_buffer_clr   (lb_clr[g]),
      .output_buffer_available    (avail),
      .output_buffer_available_clr(avail_clr[g]),
      .output_buffer_we           (we[g]),
      .last_output_block_wr       (last_wr[g]),
      .state_reset                (st_rst[g]),
      .absorb_enable              (absorb[g]),
      .round_en                   (ren[g]),
      .round_idx                  (ridx[g]),
      .copy_control_data          (copy[g]),
      .rate_lanes                 (rate[g]),
      .busy                       (busy[g])
    );
  end

  task automatic test_reset();
    logic [9:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    v = {ibr_clr[0], lb_clr[0], avail_clr[0], we[0], last_wr[0], st_rst[0], absorb[0], ren[0], copy[0], busy[0]};
    checks++; if (v !== 10'b0) begin errors++; $display("FAIL reset_outputs: got %b want 0", v); end
    checks++; if (rate[0] !== 5'd21) begin errors++; $display("FAIL reset_rate: got %0d want 21", rate[0]); end
    checks++; if (ridx[0] !== 5'd0) begin errors++; $display("FAIL reset_ridx: got %0d want 0", ridx[0]); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    v = {st_rst[0], ibr_clr[0], lb_clr[0], busy[0], ren[0], absorb[0], we[0], 3'b000};
    checks++; if (v !== 10'b1111000000) begin errors++; $display("FAIL reset_pulse: got %b want 1111000000", v); end
    @(negedge clk);
    checks++; if ({busy[0], st_rst[0]} !== 2'b00) begin errors++; $display("FAIL reset_wait: got %b want 00", {busy[0], st_rst[0]}); end
  endtask

  task automatic test_single_block();
    int n_ren = 0, n_abs = 0, n_wr = 0, n_lastwr = 0, n_copy = 0, t_abs = 0, t_wr = 0, overlap = 0, clr_bad = 0;
    logic wr_srst = 1'b0;
    logic give = 1'b1;
    cfg_mode = MODE_SHAKE128; cfg_out_blocks = '0; avail = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      ibr = give; lbi = give;
      @(negedge clk);
      if (ibr_clr[0]) give = 1'b0;
      if (ren[0]) n_ren++;
      if (absorb[0]) begin n_abs++; t_abs = c; end
      if (absorb[0] && ren[0]) overlap++;
      if (copy[0]) n_copy++;
      if (avail_clr[0] !== we[0]) clr_bad++;
      if (we[0]) begin n_wr++; t_wr = c; n_lastwr += int'(last_wr[0]); wr_srst = st_rst[0]; end
    end
    checks++; if (n_ren !== 24) begin errors++; $display("FAIL single_ren: got %0d want 24", n_ren); end
    checks++; if (n_wr !== 1) begin errors++; $display("FAIL single_writes: got %0d want 1", n_wr); end
    checks++; if (n_lastwr !== 1) begin errors++; $display("FAIL single_lastwr: got %0d want 1", n_lastwr); end
    checks++; if (wr_srst !== 1'b1) begin errors++; $display("FAIL single_wr_state_reset: got %b want 1", wr_srst); end
    checks++; if (t_wr - t_abs !== 25) begin errors++; $display("FAIL single_latency: got %0d want 25", t_wr - t_abs); end
    checks++; if (n_abs !== 1 || n_copy !== 1) begin errors++; $display("FAIL single_abs_copy: got %0d/%0d want 1/1", n_abs, n_copy); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL single_overlap: got %0d want 0", overlap); end
    checks++; if (clr_bad !== 0) begin errors++; $display("FAIL single_avail_clr: got %0d want 0", clr_bad); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy[0]); end
  endtask

  task automatic test_multi_block();
    int k = 0, n_abs = 0, n_wr = 0, n_copy = 0, n_lbclr = 0, idle = 0;
    int t [3];
    cfg_mode = MODE_SHAKE256; cfg_out_blocks = '0; avail = 1'b1;
    for (int c = 0; c < 82; c++) begin
      @(posedge clk); #1;
      ibr = (k < 3); lbi = (k == 2);
      @(negedge clk);
      if (ibr_clr[0]) k++;
      if (lb_clr[0]) n_lbclr++;
      if (copy[0]) n_copy++;
      if (n_abs > 0 && n_wr == 0 && !busy[0]) idle++;
      if (absorb[0]) begin if (n_abs < 3) t[n_abs] = c; n_abs++; end
      if (we[0]) n_wr++;
    end
    checks++; if (n_abs !== 3) begin errors++; $display("FAIL multi_absorbs: got %0d want 3", n_abs); end
    checks++; if (t[1] - t[0] !== 25 || t[2] - t[1] !== 25) begin errors++; $display("FAIL multi_spacing: got %0d,%0d want 25,25", t[1] - t[0], t[2] - t[1]); end
    checks++; if (idle !== 0) begin errors++; $display("FAIL multi_wait_entered: got %0d idle cycles want 0", idle); end
    checks++; if (n_copy !== 1 || n_lbclr !== 1) begin errors++; $display("FAIL multi_copy_lbclr: got %0d/%0d want 1/1", n_copy, n_lbclr); end
    checks++; if (n_wr !== 1) begin errors++; $display("FAIL multi_writes: got %0d want 1", n_wr); end
    checks++; if (rate[0] !== 5'd17) begin errors++; $display("FAIL multi_rate: got %0d want 17", rate[0]); end
  endtask

  task automatic test_out_stall();
    int n_wr = 0, w1 = -100, stall_ren = 0, stall_we = 0, stall_idle = 0;
    int wt [4];
    logic [3:0] lastv = '0;
    logic give = 1'b1;
    cfg_mode = MODE_SHAKE256; cfg_out_blocks = OUT_CNT_W'(2);
    for (int c = 0; c < 90; c++) begin
      @(posedge clk); #1;
      ibr = give; lbi = give;
      avail = !(c >= w1 + 25 && c < w1 + 30);
      @(negedge clk);
      if (ibr_clr[0]) give = 1'b0;
      if (!avail) begin
        stall_ren += int'(ren[0]); stall_we += int'(we[0]); stall_idle += int'(!busy[0]);
      end
      if (we[0]) begin
        if (n_wr == 0) w1 = c;
        if (n_wr < 4) begin wt[n_wr] = c; lastv[n_wr] = last_wr[0]; end
        n_wr++;
      end
    end
    avail = 1'b1;
    checks++; if (n_wr !== 3) begin errors++; $display("FAIL stall_writes: got %0d want 3", n_wr); end
    checks++; if (lastv !== 4'b0100) begin errors++; $display("FAIL stall_last_flags: got %b want 0100", lastv); end
    checks++; if (wt[1] - wt[0] !== 30) begin errors++; $display("FAIL stall_gap2: got %0d want 30", wt[1] - wt[0]); end
    checks++; if (wt[2] - wt[1] !== 25) begin errors++; $display("FAIL stall_gap3: got %0d want 25", wt[2] - wt[1]); end
    checks++; if (stall_ren !== 0 || stall_we !== 0) begin errors++; $display("FAIL stall_quiet: got ren=%0d we=%0d want 0/0", stall_ren, stall_we); end
    checks++; if (stall_idle !== 0) begin errors++; $display("FAIL stall_busy: got %0d idle want 0", stall_idle); end
  endtask

  task automatic test_back_to_back();
    int phase = 0, n_wr = 0, t_wr_a = -1, t_triple = -1, n_triple = 0, idle = 0, n_abs = 0;
    int rate_a = -1;
    logic [3:0] lastv = '0;
    logic wr_a_srst = 1'b0;
    logic seen_copy = 1'b0;
    cfg_mode = MODE_SHA3_512; cfg_out_blocks = OUT_CNT_W'(7); avail = 1'b1;
    for (int c = 0; c < 84; c++) begin
      @(posedge clk); #1;
      if (seen_copy) begin cfg_mode = MODE_SHAKE128; cfg_out_blocks = OUT_CNT_W'(1); end
      ibr = (phase < 2); lbi = 1'b1;
      @(negedge clk);
      if (copy[0]) seen_copy = 1'b1;
      if (ibr_clr[0]) phase++;
      if (absorb[0]) n_abs++;
      if (ren[0] && rate_a < 0) rate_a = int'(rate[0]);
      if (n_abs > 0 && n_wr < 3 && !busy[0]) idle++;
      if (st_rst[0] && absorb[0] && copy[0]) begin n_triple++; t_triple = c; end
      if (we[0]) begin
        if (n_wr == 0) begin t_wr_a = c; wr_a_srst = st_rst[0]; end
        if (n_wr < 4) lastv[n_wr] = last_wr[0];
        n_wr++;
      end
    end
    checks++; if (rate_a !== 9) begin errors++; $display("FAIL b2b_rate_a: got %0d want 9", rate_a); end
    checks++; if (wr_a_srst !== 1'b1) begin errors++; $display("FAIL b2b_dump_state_reset: got %b want 1", wr_a_srst); end
    checks++; if (n_triple !== 1 || t_triple !== t_wr_a + 1) begin errors++; $display("FAIL b2b_triple: got n=%0d at %0d want n=1 at %0d", n_triple, t_triple, t_wr_a + 1); end
    checks++; if (rate[0] !== 5'd21) begin errors++; $display("FAIL b2b_rate_b: got %0d want 21", rate[0]); end
    checks++; if (n_wr !== 3 || lastv !== 4'b0101) begin errors++; $display("FAIL b2b_writes: got %0d flags %b want 3 flags 0101", n_wr, lastv); end
    checks++; if (idle !== 0) begin errors++; $display("FAIL b2b_idle: got %0d want 0", idle); end
  endtask

  task automatic test_reset_mid_permute();
    logic [9:0] v;
    logic hit = 1'b0;
    logic give = 1'b1;
    cfg_mode = MODE_SHAKE128; cfg_out_blocks = '0; avail = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(posedge clk); #1;
      ibr = give; lbi = give;
      @(negedge clk);
      if (ibr_clr[0]) give = 1'b0;
      if (ren[0] && ridx[0] == 5'd10) hit = 1'b1;
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rst_mid_reach: got %b want 1", hit); end
    rst = 1'b1; ibr = 1'b0; lbi = 1'b0;
    #1;
    v = {ibr_clr[0], lb_clr[0], avail_clr[0], we[0], last_wr[0], st_rst[0], absorb[0], ren[0], copy[0], busy[0]};
    checks++; if (v !== 10'b0 || ridx[0] !== 5'd0) begin errors++; $display("FAIL rst_mid_async: got %b idx %0d want 0 idx 0", v, ridx[0]); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({we[0], ren[0], busy[0], st_rst[0]} !== 4'b0 || rate[0] !== 5'd21) begin errors++; $display("FAIL rst_mid_hold: got %b rate %0d want 0000 rate 21", {we[0], ren[0], busy[0], st_rst[0]}, rate[0]); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if ({st_rst[0], ibr_clr[0], lb_clr[0], busy[0], ren[0]} !== 5'b11110) begin errors++; $display("FAIL rst_mid_pulse: got %b want 11110", {st_rst[0], ibr_clr[0], lb_clr[0], busy[0], ren[0]}); end
    @(negedge clk);
    checks++; if ({busy[0], st_rst[0], ren[0]} !== 3'b000) begin errors++; $display("FAIL rst_mid_wait: got %b want 000", {busy[0], st_rst[0], ren[0]}); end
  endtask

  task automatic test_rpc_sweep();
    int exp_ren [3] = '{24, 6, 1};
    int exp_idx [3] = '{23, 20, 0};
    int n_ren [3] = '{0, 0, 0};
    int n_wr [3] = '{0, 0, 0};
    int n_last [3] = '{0, 0, 0};
    int max_idx [3] = '{-1, -1, -1};
    int t_abs [3] = '{0, 0, 0};
    int t_wr [3] = '{0, 0, 0};
    logic give = 1'b1;
    cfg_mode = MODE_SHA3_512; cfg_out_blocks = OUT_CNT_W'(5); avail = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      ibr = give; lbi = give;
      @(negedge clk);
      if (ibr_clr[0]) give = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (ren[d]) begin n_ren[d]++; if (int'(ridx[d]) > max_idx[d]) max_idx[d] = int'(ridx[d]); end
        if (absorb[d]) t_abs[d] = c;
        if (we[d]) begin n_wr[d]++; t_wr[d] = c; n_last[d] += int'(last_wr[d]); end
      end
    end
    for (int d = 0; d < 3; d++) begin
      checks++; if (n_ren[d] !== exp_ren[d]) begin errors++; $display("FAIL sweep_ren[%0d]: got %0d want %0d", d, n_ren[d], exp_ren[d]); end
      checks++; if (max_idx[d] !== exp_idx[d]) begin errors++; $display("FAIL sweep_last_idx[%0d]: got %0d want %0d", d, max_idx[d], exp_idx[d]); end
      checks++; if (n_wr[d] !== 1 || n_last[d] !== 1) begin errors++; $display("FAIL sweep_single_out[%0d]: got %0d/%0d want 1/1", d, n_wr[d], n_last[d]); end
      checks++; if (t_wr[d] - t_abs[d] !== exp_ren[d] + 1) begin errors++; $display("FAIL sweep_latency[%0d]: got %0d want %0d", d, t_wr[d] - t_abs[d], exp_ren[d] + 1); end
      checks++; if (rate[d] !== 5'd9) begin errors++; $display("FAIL sweep_rate[%0d]: got %0d want 9", d, rate[d]); end
    end
  endtask

  initial begin
    rst = 1'b1; ibr = 1'b0; lbi = 1'b0; avail = 1'b0;
    cfg_mode = MODE_SHAKE128; cfg_out_blocks = '0;
    test_reset();
    test_single_block();
    test_multi_block();
    test_out_stall();
    test_back_to_back();
    test_reset_mid_permute();
    test_rpc_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
